// File: rtl/tdc_stream_rx.sv
// 8N1 UART receiver and record decoder for the TDC/MEMS serial stream.
// Emits one-cycle strobes for data, new-line and new-frame records on channels 1-6.
module tdc_stream_rx #(
    parameter int CLK_PER_BIT  = 50,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        rec_valid,
    output logic [1:0]  rec_type,
    output logic [2:0]  rec_channel,
    output logic [23:0] rec_data,
    output logic        err_framing,
    output logic        err_header,
    output logic        err_timeout,
    output logic        busy
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int TMO_W = $clog2(LIMIT + 1);

    localparam logic [1:0] TYPE_DATA  = 2'd0;
    localparam logic [1:0] TYPE_LINE  = 2'd1;
    localparam logic [1:0] TYPE_FRAME = 2'd2;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_HDR, P_PAY0, P_PAY1, P_PAY2} parse_state_t;

    uart_state_t  uart_state;
    parse_state_t parse_state;

    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [15:0]      pay_buf;
    logic [2:0]       pend_channel;
    logic [TMO_W-1:0] tmo_cnt;

    logic fall, half_end, bit_end, stop_sample, byte_ok, stop_err, hdr_ok;

    // Preset to 1 so reset release looks like an idle line, not a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall        = rx_prev & ~rx_sync;
    assign half_end    = (bit_cnt == CNT_W'(CLK_PER_BIT / 2 - 1));
    assign bit_end     = (bit_cnt == CNT_W'(CLK_PER_BIT - 1));
    assign stop_sample = (uart_state == U_STOP) && bit_end;
    assign byte_ok     = stop_sample & rx_sync;
    assign stop_err    = stop_sample & ~rx_sync;
    assign hdr_ok      = (shift[7:4] inside {4'hA, 4'hB, 4'hC}) &&
                         (shift[3:0] >= 4'd1) && (shift[3:0] <= 4'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_state <= U_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            case (uart_state)
                U_IDLE: begin
                    bit_cnt <= '0;
                    if (fall) uart_state <= U_START;
                end
                U_START: begin
                    if (half_end) begin
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        uart_state <= rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) uart_state <= U_STOP;
                        else                 bit_idx    <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        uart_state <= U_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: uart_state <= U_IDLE;
            endcase
        end
    end

    // Framing errors take priority; a delivered byte beats a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parse_state  <= P_HDR;
            rec_valid    <= 1'b0;
            rec_type     <= '0;
            rec_channel  <= '0;
            rec_data     <= '0;
            err_framing  <= 1'b0;
            err_header   <= 1'b0;
            err_timeout  <= 1'b0;
            pay_buf      <= '0;
            pend_channel <= '0;
            tmo_cnt      <= '0;
        end else begin
            rec_valid   <= 1'b0;
            err_framing <= 1'b0;
            err_header  <= 1'b0;
            err_timeout <= 1'b0;
            if (stop_err) begin
                err_framing <= 1'b1;
                parse_state <= P_HDR;
                tmo_cnt     <= '0;
            end else if (byte_ok) begin
                tmo_cnt <= '0;
                case (parse_state)
                    P_HDR: begin
                        if (!hdr_ok) begin
                            err_header <= 1'b1;
                        end else if (shift[7:4] == 4'hA) begin
                            pend_channel <= shift[2:0];
                            parse_state  <= P_PAY0;
                        end else begin
                            rec_valid   <= 1'b1;
                            rec_type    <= (shift[7:4] == 4'hB) ? TYPE_LINE : TYPE_FRAME;
                            rec_channel <= shift[2:0];
                            rec_data    <= '0;
                        end
                    end
                    P_PAY0: begin
                        pay_buf[15:8] <= shift;
                        parse_state   <= P_PAY1;
                    end
                    P_PAY1: begin
                        pay_buf[7:0] <= shift;
                        parse_state  <= P_PAY2;
                    end
                    P_PAY2: begin
                        rec_valid   <= 1'b1;
                        rec_type    <= TYPE_DATA;
                        rec_channel <= pend_channel;
                        rec_data    <= {pay_buf, shift};
                        parse_state <= P_HDR;
                    end
                    default: parse_state <= P_HDR;
                endcase
            end else if (parse_state != P_HDR) begin
                if (tmo_cnt == TMO_W'(LIMIT - 1)) begin
                    err_timeout <= 1'b1;
                    parse_state <= P_HDR;
                    tmo_cnt     <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (uart_state != U_IDLE) || (parse_state != P_HDR);

endmodule

// File: doc/tdc_stream_rx.md
# tdc_stream_rx

Serial-side receiver and record decoder for the TDC/MEMS output stream that the FIFO manager drives on `SERIAL_OUT_TDC`. It deserialises 8N1 UART bytes and parses them into data, new-line and new-frame records for channels 1–6. Each complete record is presented as a single-cycle strobe. It is used for on-board loopback checking (`SERIAL_OUT_TDC` wired to `SERIAL_IN`) and as the bench-side checker model for the transmit path.

## Interface
Parameters:
- `CLK_PER_BIT`, default 50: clocks per UART bit (50 MHz / 1 Mbaud). Must be ≥ 8.
- `TIMEOUT_BITS`, default 40: maximum gap between bytes inside a record, in bit times.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `rec_valid`  out  1  one-cycle strobe: a complete record is on `rec_*`.
- `rec_type`  out  2  0 = data, 1 = new line, 2 = new frame.
- `rec_channel`  out  3  source channel, 1–6.
- `rec_data`  out  24  TDC payload. Forced to 0 for line and frame records.
- `err_framing`  out  1  one-cycle strobe: stop bit sampled low.
- `err_header`  out  1  one-cycle strobe: invalid header byte.
- `err_timeout`  out  1  one-cycle strobe: record abandoned because of an inter-byte gap.
- `busy`  out  1  high while the UART is not idle or the parser is not in HDR.

## Operation

**UART layer**
- `rx` passes through a 2-flop synchroniser; all logic uses the synchronised value.
- States: IDLE, START, DATA, STOP.
- IDLE → START on a falling edge of synchronised rx.
- In START, wait `CLK_PER_BIT/2` clocks (integer division), then sample:
  - low: go to DATA;
  - high: treat as a glitch and return to IDLE with no strobe.
- DATA samples 8 bits LSB first, one every `CLK_PER_BIT` clocks. STOP samples once more after another `CLK_PER_BIT` clocks.
- Stop bit high: the byte is delivered to the parser.
- Stop bit low: pulse `err_framing`, discard the byte, force the parser to HDR.
- The UART returns to IDLE on the stop-sample cycle. A start edge is accepted from the next clock onward.

**Parser layer** (states HDR, PAY0, PAY1, PAY2)
- In HDR:
  - Header 0xA1–0xA6: data record for channel = low nibble; go to PAY0.
  - Header 0xB1–0xB6: new-line record; emit immediately and stay in HDR.
  - Header 0xC1–0xC6: new-frame record; emit immediately and stay in HDR.
  - Any other byte: pulse `err_header` and stay in HDR.
- Payload is MSB first: PAY0 → `rec_data[23:16]`, PAY1 → `[15:8]`, PAY2 → `[7:0]`. Completing PAY2 emits the record and returns to HDR.
- Payload bytes are never interpreted as headers; there is no escaping.
- Timeout counter:
  - Clears on every delivered byte and counts while the parser is in PAY0–PAY2.
  - On reaching `TIMEOUT_BITS*CLK_PER_BIT`: pulse `err_timeout`, discard the partial record, go to HDR.
  - If a byte delivery and the timeout coincide, the byte wins.
- `rec_type`, `rec_channel` and `rec_data` update only when `rec_valid` pulses and hold otherwise.

**Reset**
- All outputs 0 and `busy` 0.
- UART in IDLE, parser in HDR.
- Synchroniser flops preset to 1 so that reset release does not produce a false start edge.
- Reset asserted mid-byte or mid-record discards everything received.

## Timing
- Start edge on `rx` to the internal falling-edge detect: 2 clocks (synchroniser).
- Byte delivery happens on the stop-sample clock. `rec_valid` and the `rec_*` values appear on the following clock, a 1-clock registered latency.
- Error strobes follow the same rule: they assert 1 clock after the triggering sample or timeout count.
- At most one of `rec_valid`, `err_framing`, `err_header`, `err_timeout` is high in any cycle.
- Back-to-back bytes with zero idle beyond the stop bit are received without loss.
- Baud mismatch tolerance is ±2% because sampling is at mid-bit.

## Test plan
- Send A2 12 34 56 back-to-back → exactly one `rec_valid`, with type 0, channel 2, data 0x123456. `busy` is low after it.
- Send B5 then C1 → two strobes: (type 1, ch 5, data 0) then (type 2, ch 1, data 0). `err_*` never pulses.
- Send 0x7F then A1 00 00 01 → one `err_header` pulse, then a record with type 0, ch 1, data 0x000001.
- Send A3 then 0x11 with its stop bit driven low → one `err_framing` pulse and no `rec_valid`. A following A3 AA BB CC → data 0xAABBCC.
- Send A4 01 then idle → `err_timeout` pulses 2000 clocks after the delivery of 0x01, plus 1 clock of registered latency. No `rec_valid`.
- A 20-clock low glitch on `rx` is ignored. Pulling `rst_n` low during PAY1 of A6 … zeroes all outputs. A subsequent A6 DE AD 01 decodes as data 0xDEAD01.
